dap_response_packer: RTL and testbench

//  Receiving end of the command-worker output path. Workers (delay, SWJ, transfer...) push

---
 rtl/dap_pkg.sv | 13 +
 rtl/dap_byte_fifo.sv | 53 +++++
 rtl/dap_response_packer.sv | 124 ++++++++++++
 tb/tb_dap_response_packer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dap_pkg.sv
// Shared constants and packer state encoding for the DAP response path.
package dap_pkg;

  localparam logic [7:0] DAP_RESP_OK  = 8'h00;
  localparam logic [7:0] DAP_RESP_ERR = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } pk_state_e;

endpackage

// File: rtl/dap_byte_fifo.sv
// Byte FIFO with combinational head read and an occupancy count.
module dap_byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   rd_en,
  output logic [7:0]             rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_wr;
  logic          w_rd;

  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];
  assign w_wr    = wr_en & ~full;
  assign w_rd    = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dap_response_packer.sv
// Frames worker response bytes behind the echoed command ID
// and streams one AXI-Stream packet per command.
module dap_response_packer
  import dap_pkg::*;
#(
  parameter int FIFO_DEPTH = 64
) (
  input  logic       hclk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] cmd_id,
  input  logic       worker_tvalid,
  input  logic [7:0] worker_tdata,
  input  logic       worker_done,
  output logic       resp_tvalid,
  input  logic       resp_tready,
  output logic [7:0] resp_tdata,
  output logic       resp_tlast,
  output logic       overflow,
  output logic       busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  pk_state_e     r_state;
  logic          r_start_q;
  logic          r_pending;
  logic [7:0]    r_pend_id;
  logic          r_done_seen;
  logic          r_overflow;

  logic          w_rise;
  logic          w_open;
  logic          w_wr_en;
  logic [7:0]    w_wr_data;
  logic          w_pop;
  logic [7:0]    w_head;
  logic [CW-1:0] w_cnt;
  logic          w_full;
  logic          w_empty;
  logic          w_vld;
  logic          w_last;

  assign w_rise = start & ~r_start_q;
  assign w_open = (r_state == ST_IDLE) & (r_pending | w_rise);

  // A lone buffered byte waits for done so tlast is final when valid rises.
  assign w_vld  = (w_cnt >= CW'(2)) | ((w_cnt == CW'(1)) & r_done_seen);
  assign w_last = r_done_seen & (w_cnt == CW'(1));
  assign w_pop  = w_vld & resp_tready;

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_data = 8'h00;
    if (w_open) begin
      w_wr_en   = 1'b1;
      w_wr_data = r_pending ? r_pend_id : cmd_id;
    end else if (r_state == ST_COLLECT && worker_tvalid && !w_full) begin
      w_wr_en   = 1'b1;
      w_wr_data = worker_tdata;
    end
  end

  dap_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (hclk),
    .rst     (rst),
    .wr_en   (w_wr_en),
    .wr_data (w_wr_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .count   (w_cnt),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign resp_tvalid = w_vld;
  assign resp_tlast  = w_last;
  assign resp_tdata  = w_empty ? 8'h00 : w_head;
  assign overflow    = r_overflow;
  assign busy        = (r_state != ST_IDLE);

  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_start_q   <= 1'b0;
      r_pending   <= 1'b0;
      r_pend_id   <= 8'h00;
      r_done_seen <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_start_q <= start;
      if (r_state != ST_IDLE && w_rise) begin
        r_pending <= 1'b1;
        r_pend_id <= cmd_id;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_open) begin
            r_overflow  <= 1'b0;
            r_done_seen <= 1'b0;
            r_state     <= ST_COLLECT;
            // A fresh rise while serving a queued one stays queued.
            if (r_pending) begin
              r_pending <= w_rise;
              if (w_rise) r_pend_id <= cmd_id;
            end
          end
        end
        ST_COLLECT: begin
          if (worker_tvalid && w_full) r_overflow <= 1'b1;
          if (worker_done || !start) begin
            r_done_seen <= 1'b1;
            r_state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pop && w_last) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dap_response_packer.sv
// Directed bench for dap_response_packer with a queue-based
// reference model compared every cycle.
module tb_dap_response_packer;

  localparam int DEPTH = 4;

  logic       hclk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] cmd_id = 8'h00;
  logic       worker_tvalid = 1'b0;
  logic [7:0] worker_tdata = 8'h00;
  logic       worker_done = 1'b0;
  logic       resp_tvalid;
  logic       resp_tready = 1'b0;
  logic [7:0] resp_tdata;
  logic       resp_tlast;
  logic       overflow;
  logic       busy;

  int checks = 0;
  int failures = 0;

  always #5 hclk = ~hclk;

  dap_response_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .hclk          (hclk),
    .rst           (rst),
    .start         (start),
    .cmd_id        (cmd_id),
    .worker_tvalid (worker_tvalid),
    .worker_tdata  (worker_tdata),
    .worker_done   (worker_done),
    .resp_tvalid   (resp_tvalid),
    .resp_tready   (resp_tready),
    .resp_tdata    (resp_tdata),
    .resp_tlast    (resp_tlast),
    .overflow      (overflow),
    .busy          (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: the response buffer is just a byte queue.
  logic [7:0] q[$];
  bit         m_busy, m_col, m_done, m_pend, m_sq, m_ovf;
  logic [7:0] m_pid;

  function automatic bit m_vld();
    return (q.size() >= 2) || (q.size() == 1 && m_done);
  endfunction

  function automatic bit m_last();
    return m_done && q.size() == 1;
  endfunction

  always @(posedge hclk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_busy = 0; m_col = 0; m_done = 0;
      m_pend = 0; m_sq = 0; m_ovf = 0; m_pid = 8'h00;
    end else begin
      bit rise, pop, last, full, go;
      logic [7:0] hdr;
      rise = start && !m_sq;
      pop  = m_vld() && resp_tready;
      last = m_last();
      full = (q.size() == DEPTH);
      if (pop) begin
        void'(q.pop_front());
        if (last) m_busy = 0;
      end
      if (m_busy || m_col || (pop && last)) begin
        if (rise) begin m_pend = 1; m_pid = cmd_id; end
        if (m_col) begin
          if (worker_tvalid) begin
            if (full) m_ovf = 1;
            else q.push_back(worker_tdata);
          end
          if (worker_done || !start) begin m_done = 1; m_col = 0; end
        end
      end else begin
        go = m_pend || rise;
        if (go) begin
          hdr = m_pend ? m_pid : cmd_id;
          q.push_back(hdr);
          if (m_pend) begin
            m_pend = rise;
            if (rise) m_pid = cmd_id;
          end
          m_ovf = 0; m_done = 0; m_busy = 1; m_col = 1;
        end
      end
      m_sq = start;
    end
  end

  always @(negedge hclk) begin
    if (!rst) begin
      chk("tvalid", resp_tvalid, m_vld());
      chk("tlast", resp_tlast, m_last());
      chk("tdata", resp_tdata, q.size() > 0 ? q[0] : 8'h00);
      chk("busy", busy, m_busy);
      chk("overflow", overflow, m_ovf);
    end
  end

  logic [8:0] got[$];
  always @(negedge hclk) begin
    if (!rst && resp_tvalid && resp_tready)
      got.push_back({resp_tlast, resp_tdata});
  end

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic open_pkt(input logic [7:0] id);
    start = 1'b1;
    cmd_id = id;
    cyc();
  endtask

  task automatic push(input logic [7:0] b);
    worker_tvalid = 1'b1;
    worker_tdata = b;
    cyc();
    worker_tvalid = 1'b0;
  endtask

  task automatic finish_pkt();
    worker_done = 1'b1;
    start = 1'b0;
    cyc();
    worker_done = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 200) begin
      cyc();
      n++;
    end
    chk({nm, "_idle"}, busy, 1'b0);
  endtask

  task automatic check_pkt(input string nm, input logic [8:0] e[$]);
    chk({nm, "_len"}, got.size(), e.size());
    for (int i = 0; i < e.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s_beat%0d", nm, i), got[i], e[i]);
    end
    got.delete();
  endtask

  initial begin
    logic [8:0] e[$];
    #2;
    chk("rst_tvalid", resp_tvalid, 1'b0);
    chk("rst_tdata", resp_tdata, 8'h00);
    chk("rst_tlast", resp_tlast, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    cyc();
    rst = 1'b0;
    cyc();

    resp_tready = 1'b1;
    open_pkt(8'h09);
    chk("t1_hdr_busy", busy, 1'b1);
    push(8'h00);
    finish_pkt();
    wait_idle("t1");
    e = '{9'h009, 9'h100};
    check_pkt("t1", e);

    resp_tready = 1'b0;
    open_pkt(8'h05);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    finish_pkt();
    repeat (16) cyc();
    chk("t2_hold_tvalid", resp_tvalid, 1'b1);
    chk("t2_hold_tdata", resp_tdata, 8'h05);
    chk("t2_hold_tlast", resp_tlast, 1'b0);
    resp_tready = 1'b1;
    wait_idle("t2");
    e = '{9'h005, 9'h011, 9'h022, 9'h133};
    check_pkt("t2", e);

    open_pkt(8'h09);
    finish_pkt();
    wait_idle("t3");
    e = '{9'h109};
    check_pkt("t3", e);

    resp_tready = 1'b0;
    open_pkt(8'h09);
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    push(8'hA4);
    push(8'hA5);
    finish_pkt();
    chk("t4_ovf", overflow, 1'b1);
    resp_tready = 1'b1;
    wait_idle("t4");
    e = '{9'h009, 9'h0A1, 9'h0A2, 9'h1A3};
    check_pkt("t4", e);
    chk("t4_ovf_sticky", overflow, 1'b1);

    open_pkt(8'h09);
    chk("t5_ovf_clr", overflow, 1'b0);
    push(8'hAA);
    start = 1'b0;
    cyc();
    wait_idle("t5");
    e = '{9'h009, 9'h1AA};
    check_pkt("t5", e);

    open_pkt(8'h09);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t6_withheld", resp_tvalid, 1'b0);
    end
    resp_tready = 1'b0;
    finish_pkt();
    chk("t6_drain_tvalid", resp_tvalid, 1'b1);
    chk("t6_drain_tlast", resp_tlast, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", resp_tvalid, 1'b0);
    chk("t6_rst_tdata", resp_tdata, 8'h00);
    chk("t6_rst_tlast", resp_tlast, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    got.delete();
    cyc();
    rst = 1'b0;
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
